// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, runs a single-outstanding req/ack
// fetch to instruction memory and queues returned words with their PCs for decode.
//
// state | meaning
// IDLE  | no request outstanding; issue when the buffer has room
// BUSY  | request outstanding, returned data will be kept
// DRAIN | request outstanding after a redirect, returned data is discarded
module fetch_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] fetch_count
);

  localparam int            PW      = $clog2(BUF_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] buf_instr [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc    [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW:0]           count;
  logic [DATA_WIDTH-1:0] redirect_tgt;
  logic                  push;
  logic                  pop;
  logic                  unused_pc_lsb;

  assign redirect_tgt  = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_pc_lsb = &{1'b0, redirect_pc[1:0]};

  // A redirect hides the head so decode never consumes a word that is being flushed.
  assign instr_valid = (count != '0) && !redirect_valid;
  assign instr       = buf_instr[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == BUSY) && imem_ack && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
          end else if (count < DEPTH_C) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
            fetch_pc <= redirect_valid ? redirect_tgt : fetch_pc + DATA_WIDTH'(4);
          end else if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect_valid) fetch_pc <= redirect_tgt;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Flush beats any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= imem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + DATA_WIDTH'(1);
  end

endmodule
